// File: rtl/pseudo_lru_if.sv
// pseudo_lru_if: bundle between a cache controller and the pseudo-LRU engine.
//   load      - controller -> engine, capture update(set_p_lru, mru_idx) this edge
//   set_p_lru - controller -> engine, stored tree bits of the set (heap order, bit 0 unused)
//   mru_idx   - controller -> engine, way just hit or filled
//   lru_idx   - engine -> controller, current victim way
// master modport is the controller side, slave modport is the engine side.
interface pseudo_lru_if #(
  parameter int SIZE = 8
);
  localparam int IDX_W = $clog2(SIZE);

  logic             load;
  logic [SIZE-1:0]  set_p_lru;
  logic [IDX_W-1:0] mru_idx;
  logic [IDX_W-1:0] lru_idx;

  modport master (
    output load,
    output set_p_lru,
    output mru_idx,
    input  lru_idx
  );

  modport slave (
    input  load,
    input  set_p_lru,
    input  mru_idx,
    output lru_idx
  );
endinterface

// File: rtl/pseudo_lru.sv
// pseudo_lru: tree pseudo-LRU replacement engine for one cache set of SIZE ways.
// On load, registers the set's tree bits with the path to mru_idx flipped to
// point away from it; continuously presents the victim way walked from the
// registered tree.
//   clk - clock, rising edge
//   rst - asynchronous reset, active low (0 clears the tree)
//   bus - pseudo_lru_if slave: load, set_p_lru, mru_idx in; lru_idx out
// SIZE must be a power of two and at least 2.
module pseudo_lru #(
  parameter int SIZE = 8
) (
  input  logic         clk,
  input  logic         rst,
  pseudo_lru_if.slave  bus
);
  localparam int IDX_W = $clog2(SIZE);

  logic [SIZE-1:0]  tree_reg;
  logic [SIZE-1:0]  tree_next;
  logic [IDX_W-1:0] anc_node [IDX_W];
  logic [IDX_W-1:0] walk_node;
  logic [IDX_W-1:0] victim;

  // Bit 0 of the stored tree carries no node; it is deliberately dropped.
  logic unused_set_lsb;
  assign unused_set_lsb = bus.set_p_lru[0];

  // Ancestor of leaf SIZE+mru_idx at each level: a leading 1 followed by the
  // top gi bits of the way index (root is node 1).
  generate
    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_anc
      if (gi == 0) begin : g_root
        assign anc_node[gi] = IDX_W'(1);
      end else begin : g_inner
        assign anc_node[gi] = IDX_W'({1'b1, bus.mru_idx[IDX_W-1 -: gi]});
      end
    end
  endgenerate

  // Copy the stored bits, then make every node on the MRU path point away
  // from the accessed way (opposite of the way-index bit at that level).
  always_comb begin
    tree_next = {bus.set_p_lru[SIZE-1:1], 1'b0};
    for (int l = 0; l < IDX_W; l++) begin
      tree_next[anc_node[l]] = ~bus.mru_idx[IDX_W-1-l];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tree_reg <= '0;
    end else if (bus.load) begin
      tree_reg <= tree_next;
    end
  end

  // Victim walk: each visited node's bit is the next way-index bit (MSB first)
  // and also selects the child to visit. The shift on the final level spills
  // past IDX_W bits, which is harmless because the walk ends there.
  always_comb begin
    walk_node = IDX_W'(1);
    victim    = '0;
    for (int l = 0; l < IDX_W; l++) begin
      victim[IDX_W-1-l] = tree_reg[walk_node];
      walk_node         = (walk_node << 1) | IDX_W'(tree_reg[walk_node]);
    end
  end

  assign bus.lru_idx = victim;
endmodule

// File: tb/tb_pseudo_lru.sv
// tb_pseudo_lru: scoreboard bench for pseudo_lru (SIZE=8). Stimulus pushes the
// expected lru_idx with the cycle it becomes due; a negedge monitor pops and
// compares.
module tb_pseudo_lru;
  localparam int SIZE = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pseudo_lru_if #(.SIZE(SIZE)) bus ();

  pseudo_lru #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] exp;
    logic [2:0] mru;
    bit         chk_ne;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] model_t;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: walk root to leaf with heap arithmetic.
  function automatic logic [7:0] ref_update(input logic [7:0] b, input logic [2:0] w);
    logic [7:0] t;
    int n;
    t = b;
    t[0] = 1'b0;
    n = 1;
    for (int l = 0; l < 3; l++) begin
      t[n] = ~w[2-l];
      n = 2 * n + int'(w[2-l]);
    end
    return t;
  endfunction

  function automatic logic [2:0] ref_victim(input logic [7:0] t);
    int n;
    n = 1;
    for (int l = 0; l < 3; l++) n = 2 * n + int'(t[n]);
    return 3'(n - 8);
  endfunction

  task automatic expect_at(input int due, input logic [2:0] e, input logic [2:0] m,
                           input bit ne, input string nm);
    exp_t x;
    x.due = due; x.exp = e; x.mru = m; x.chk_ne = ne; x.name = nm;
    q.push_back(x);
  endtask

  // Monitor: compare every entry that has come due.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (bus.lru_idx !== e.exp) begin
        n_mis++;
        $display("FAIL %s: lru_idx=%0d required %0d (cycle %0d)", e.name, bus.lru_idx, e.exp, cyc);
      end
      if (e.chk_ne) begin
        n_cmp++;
        if (bus.lru_idx === e.mru) begin
          n_mis++;
          $display("FAIL %s_ne: lru_idx=%0d equals mru_idx=%0d", e.name, bus.lru_idx, e.mru);
        end
      end
    end
  end

  // Called at a negedge: one-cycle load pulse, then idle cycles checking hold.
  task automatic do_load(input logic [7:0] b, input logic [2:0] w, input logic [2:0] e,
                         input int idle, input string nm);
    bus.load = 1'b1;
    bus.set_p_lru = b;
    bus.mru_idx = w;
    expect_at(cyc + 1, e, w, 1'b1, nm);
    $display("load %s set_p_lru=%02h mru=%0d exp_lru=%0d", nm, b, w, e);
    @(negedge clk);
    bus.load = 1'b0;
    bus.set_p_lru = 8'hA5;
    bus.mru_idx = 3'd6;
    for (int i = 0; i < idle; i++) begin
      expect_at(cyc + 1, e, w, 1'b0, {nm, "_hold"});
      @(negedge clk);
    end
  endtask

  initial begin
    bus.load = 1'b0;
    bus.set_p_lru = '0;
    bus.mru_idx = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_at(cyc + 1, 3'd0, 3'd0, 1'b0, "reset_lru");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_at(cyc + 1, 3'd0, 3'd0, 1'b0, "post_reset_idle");
      @(negedge clk);
    end

    // Directed, hand-computed.
    do_load(8'h00, 3'd0, 3'd4, 1, "single");
    do_load(8'hFE, 3'd7, 3'd3, 5, "corner");
    do_load(8'h01, 3'd5, 3'd0, 1, "bit0_set");
    do_load(8'h00, 3'd5, 3'd0, 1, "bit0_clr");

    // Back-to-back loads.
    bus.load = 1'b1;
    bus.set_p_lru = 8'h00; bus.mru_idx = 3'd0;
    expect_at(cyc + 1, 3'd4, 3'd0, 1'b1, "btb0");
    @(negedge clk);
    bus.set_p_lru = 8'hFE; bus.mru_idx = 3'd7;
    expect_at(cyc + 1, 3'd3, 3'd7, 1'b1, "btb1");
    @(negedge clk);
    bus.set_p_lru = 8'h01; bus.mru_idx = 3'd5;
    expect_at(cyc + 1, 3'd0, 3'd5, 1'b1, "btb2");
    @(negedge clk);
    bus.load = 1'b0;
    expect_at(cyc + 1, 3'd0, 3'd5, 1'b0, "btb_hold");
    @(negedge clk);

    // Exhaustive sweep against the reference model.
    for (int b = 0; b < 256; b++) begin
      for (int w = 0; w < 8; w++) begin
        model_t = ref_update(8'(b), 3'(w));
        do_load(8'(b), 3'(w), ref_victim(model_t), 1, "sweep");
      end
    end

    // Asynchronous reset mid-run, no clock edge before the check.
    do_load(8'h00, 3'd0, 3'd4, 0, "pre_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.load = 1'b1;
    bus.set_p_lru = 8'h00;
    bus.mru_idx = 3'd0;
    expect_at(cyc, 3'd0, 3'd0, 1'b0, "async_rst");
    @(negedge clk);
    expect_at(cyc + 1, 3'd0, 3'd0, 1'b0, "rst_held_load");
    @(negedge clk);
    rst = 1'b1;
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_at(cyc + 1, 3'd0, 3'd0, 1'b0, "rst_release_idle");
      @(negedge clk);
    end

    // Bounded drain of anything still queued.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/pseudo_lru.md
Name: pseudo_lru

Overview:
- Tree-based pseudo-LRU (PLRU) replacement engine for one cache set with SIZE ways.
- On load, it takes the set's stored PLRU tree bits and the way index just accessed (MRU). It then registers the updated tree.
- It continuously presents the victim (LRU) way index computed from the registered tree.
- It sits beside the cache tag/data arrays. The controller drives the set's stored bits and the hit/fill way, then uses lru_idx for replacement.

Parameters:
- SIZE, 8, number of ways. Must be a power of two, >= 2. Tree has SIZE-1 node bits in heap order.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  when 1 at a rising edge, tree register <= update(set_p_lru, mru_idx).
- set_p_lru  input  SIZE  stored tree bits. Heap-indexed: bit k is node k for k = 1..SIZE-1. Bit 0 is unused and ignored.
- mru_idx  input  $clog2(SIZE)  way just accessed; marked most recently used during load.
- lru_idx  output  $clog2(SIZE)  current victim way, combinational from the tree register.

Behaviour:
- State: tree register T[SIZE-1:0]. Bit 0 is always held 0.
- Reset:
  - rst=0 clears T to all zeros asynchronously, regardless of clk or load.
  - While rst=0, lru_idx = 0.
  - After rst deasserts, T stays 0 until the first load.
- Node semantics, node k in 1..SIZE-1:
  - Bit 0 = LRU lies in the left subtree (child 2k, lower way indices).
  - Bit 1 = LRU lies in the right subtree (child 2k+1).
  - Leaves are nodes SIZE..2*SIZE-1; leaf SIZE+w is way w.
- Victim traversal (combinational):
  - Start at n = 1 and repeat log2(SIZE) times: n = 2n + T[n].
  - lru_idx = n - SIZE.
- Update function update(B, w):
  - Start from B with bit 0 forced to 0.
  - For level l = 0..log2(SIZE)-1, let node n_l be the ancestor of leaf SIZE+w at that level (n_0 = 1).
  - Let b_l be bit (log2(SIZE)-1-l) of w, i.e. the MSB first.
  - Set node n_l bit to ~b_l, so it points away from w.
  - All off-path bits are copied from B unchanged.
- Load:
  - load=1 at a rising edge (rst=1) writes T <= update(set_p_lru, mru_idx).
  - lru_idx reflects the new T after that edge, i.e. 1-cycle latency from inputs to output.
- Hold: load=0 leaves T unchanged; set_p_lru and mru_idx are don't-care.
- There is no handshake. load may be asserted every cycle, and back-to-back loads each fully replace T.
- Boundary rules:
  - mru_idx is always in range, because its width exactly covers the ways.
  - After any load, lru_idx != mru_idx.
  - set_p_lru[0] never affects any output.
- SIZE=2: a single node. lru_idx = T[1]; load sets T[1] = ~mru_idx.

Test Plan:
- Reset: drive rst=0 mid-run after loads, with no clock edge -> lru_idx becomes 0 immediately. After release, it holds 0 with load=0.
- Single update (SIZE=8): load=1, set_p_lru=0x00, mru_idx=0 -> next cycle T=0x16, lru_idx=4.
- Opposite corner: load=1, set_p_lru=0xFE, mru_idx=7 -> T=0x74, lru_idx=3. Then hold load=0 for 5 cycles -> lru_idx stays 3.
- Bit 0 ignored: load set_p_lru=0x01 vs 0x00 with mru_idx=5 -> identical lru_idx (=0 for both) and identical T.
- Exhaustive sweep: for set_p_lru = 0..255 and each mru_idx = 0..7, pulse load for one cycle then idle one cycle. Check that lru_idx matches the reference traversal/update model and that lru_idx != mru_idx every time.
- Back-to-back loads: load held high for 3 cycles with differing set_p_lru/mru_idx -> each cycle's lru_idx reflects only the previous edge's inputs.
